down_counter_timer: RTL

//   Loadable down-counter / interval timer; the decrementing counterpart of the
//   4-bit enable counter. Accepts a start value over a valid/ready load port.

---
 rtl/down_counter_timer.sv | 95 +++++++++
 1 files changed

// File: rtl/down_counter_timer.sv
// Loadable down-counter / interval timer with one-shot and auto-reload modes.
// A valid/ready load port starts a run; tc_pulse strobes once per terminal count.
module down_counter_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_value,
  output logic             load_ready,
  input  logic             enable,
  input  logic             auto_reload,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc_pulse,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] reload_reg;
  logic             load_take;
  logic             run_step;
  logic             term_step;

  assign load_take = load_valid && load_ready && !abort;
  assign run_step  = (state == RUN) && enable;
  assign term_step = run_step && (count == ONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = IDLE;
    end else if (load_take) begin
      state_next = (load_value == ZERO) ? DONE : RUN;
    end else if (term_step && !auto_reload) begin
      state_next = DONE;
    end
  end

  always_comb begin
    busy       = (state == RUN);
    load_ready = (state == IDLE) || (state == DONE);
  end

  // A zero load has no cycles to count, so its terminal strobe fires right away.
  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= ZERO;
      reload_reg <= ZERO;
      tc_pulse   <= 1'b0;
      done       <= 1'b0;
    end else begin
      tc_pulse <= 1'b0;
      if (abort) begin
        count <= ZERO;
        done  <= 1'b0;
      end else if (load_take) begin
        count      <= load_value;
        reload_reg <= load_value;
        done       <= (load_value == ZERO);
        tc_pulse   <= (load_value == ZERO);
      end else if (term_step) begin
        tc_pulse <= 1'b1;
        if (auto_reload) begin
          count <= reload_reg;
        end else begin
          count <= ZERO;
          done  <= 1'b1;
        end
      end else if (run_step && (count > ONE)) begin
        count <= count - ONE;
      end
    end
  end

endmodule
